// File: rtl/alu_ez_pkg.sv
// ============================================================================
// alu_ez_pkg : opcode/funct encodings and ALU operation types
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_ez_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_F_ADD = 6'b100000;
  localparam logic [5:0] FN_F_SUB = 6'b100010;
  localparam logic [5:0] FN_F_AND = 6'b100100;
  localparam logic [5:0] FN_F_OR  = 6'b100101;
  localparam logic [5:0] FN_F_XOR = 6'b100110;
  localparam logic [5:0] FN_F_NOR = 6'b100111;
  localparam logic [5:0] FN_F_SLT = 6'b101010;
  localparam logic [5:0] FN_F_SLL = 6'b000000;
  localparam logic [5:0] FN_F_SRL = 6'b000010;
  localparam logic [5:0] FN_F_SRA = 6'b000011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_ZERO = 4'd10
  } alu_fn_e;

endpackage

`default_nettype wire

// File: rtl/alu_ez_core.sv
// ============================================================================
// alu_ez_core : combinational ALU, shifts act on b by shamt
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_ez_core
  import alu_ez_pkg::*;
#(
  parameter int DW = 32
) (
  input  alu_fn_e       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    shamt,
  output logic [DW-1:0] y,
  output logic          zero
);

  logic w_lt;
  assign w_lt = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {{(DW-1){1'b0}}, w_lt};
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      ALU_SRA: y = DW'($signed(b) >>> shamt);
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

`default_nettype wire

// File: rtl/alu_ez_decoder.sv
// ============================================================================
// alu_ez_decoder : instruction decode, operand select, ALU and stage register
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_ez_decoder
  import alu_ez_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    instr,
  input  logic [DW-1:0]  rs_val,
  input  logic [DW-1:0]  rt_val,
  output logic [5:0]     opcode,
  output logic [RAW-1:0] rs,
  output logic [RAW-1:0] rt,
  output logic [RAW-1:0] rd,
  output logic [4:0]     shamt,
  output logic [5:0]     funct,
  output logic [15:0]    imm,
  output logic [25:0]    address,
  output logic           RegWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RegDst,
  output logic           ALUSrc,
  output logic           Branch,
  output logic           Jump,
  output logic [1:0]     ALUOp,
  output logic           PCSrc,
  output logic           illegal,
  output logic [DW-1:0]  alu_y,
  output logic           zero,
  output logic [DW-1:0]  res_q,
  output logic [RAW-1:0] wr_reg_q,
  output logic           wr_en_q,
  output logic           mem_rd_q,
  output logic           mem_wr_q
);

  aluop_e        w_aluop;
  alu_fn_e       w_fn;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_imm_ext;

  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign shamt   = instr[10:6];
  assign funct   = instr[5:0];
  assign imm     = instr[15:0];
  assign address = instr[25:0];

  always_comb begin
    {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b0000000;
    w_aluop = ALUOP_ADD;
    w_fn    = ALU_ZERO;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b1001000;
        w_aluop = ALUOP_FUNCT;
        case (funct)
          FN_F_ADD: w_fn = ALU_ADD;
          FN_F_SUB: w_fn = ALU_SUB;
          FN_F_AND: w_fn = ALU_AND;
          FN_F_OR:  w_fn = ALU_OR;
          FN_F_XOR: w_fn = ALU_XOR;
          FN_F_NOR: w_fn = ALU_NOR;
          FN_F_SLT: w_fn = ALU_SLT;
          FN_F_SLL: w_fn = ALU_SLL;
          FN_F_SRL: w_fn = ALU_SRL;
          FN_F_SRA: w_fn = ALU_SRA;
          default:  illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b1100100;
        w_fn = ALU_ADD;
      end
      OP_SW: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b0010100;
        w_fn = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b0000010;
        w_aluop = ALUOP_SUB;
        w_fn    = ALU_SUB;
      end
      OP_ADDI: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b1000100;
        w_fn = ALU_ADD;
      end
      // slti has no dedicated ALUOp code; the opcode itself selects the compare
      OP_SLTI: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b1000100;
        w_aluop = ALUOP_IMM;
        w_fn    = ALU_SLT;
      end
      OP_ANDI, OP_ORI: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b1000100;
        w_aluop = ALUOP_IMM;
        w_fn    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
      end
      OP_J: begin
        {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump} = 7'b0000001;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ALUOp     = w_aluop;
  assign w_imm_ext = (opcode == OP_ANDI || opcode == OP_ORI) ? {{(DW-16){1'b0}}, imm}
                                                             : {{(DW-16){imm[15]}}, imm};
  assign w_b       = ALUSrc ? w_imm_ext : rt_val;

  alu_ez_core #(.DW(DW)) u_core (
    .op    (w_fn),
    .a     (rs_val),
    .b     (w_b),
    .shamt (shamt),
    .y     (alu_y),
    .zero  (zero)
  );

  assign PCSrc = Branch & ((opcode == OP_BEQ) ? zero : ~zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q    <= '0;
      wr_reg_q <= '0;
      wr_en_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      res_q    <= alu_y;
      wr_reg_q <= RegDst ? rd : rt;
      wr_en_q  <= RegWrite & ~illegal;
      mem_rd_q <= MemRead & ~illegal;
      mem_wr_q <= MemWrite & ~illegal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_ez_decoder.sv
// ============================================================================
// tb_alu_ez_decoder : directed vectors with hand-computed expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_ez_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, rs_val, rt_val;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wr_reg_q;
  logic [15:0] imm;
  logic [25:0] address;
  logic        RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump;
  logic [1:0]  ALUOp;
  logic        PCSrc, illegal, zero, wr_en_q, mem_rd_q, mem_wr_q;
  logic [31:0] alu_y, res_q;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ez_decoder dut (
    .clk(clk), .reset(reset), .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .address(address), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch),
    .Jump(Jump), .ALUOp(ALUOp), .PCSrc(PCSrc), .illegal(illegal), .alu_y(alu_y),
    .zero(zero), .res_q(res_q), .wr_reg_q(wr_reg_q), .wr_en_q(wr_en_q),
    .mem_rd_q(mem_rd_q), .mem_wr_q(mem_wr_q)
  );

  wire [6:0] ctl = {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Branch, Jump};
  wire [6:0] qv  = {wr_en_q, mem_rd_q, mem_wr_q, 4'b0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr  = ins;
    rs_val = a;
    rt_val = b;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    instr  = 32'h0;
    rs_val = 32'h0;
    rt_val = 32'h0;
    #3;
    chk("reset_res_q", res_q, 32'h0);
    chk("reset_q_ctl", {25'h0, qv}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // R add $3 = $1 + $2
    @(negedge clk);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'd5, 32'd7);
    chk("add_y", alu_y, 32'd12);
    chk("add_ctl", {25'h0, ctl}, {25'h0, 7'b1001000});
    chk("add_aluop", {30'h0, ALUOp}, 32'd2);
    chk("add_fields", {rs, rt, rd, 17'h0}, {5'd1, 5'd2, 5'd3, 17'h0});
    tick();
    chk("add_res_q", res_q, 32'd12);
    chk("add_wr_reg_q", {27'h0, wr_reg_q}, 32'd3);
    chk("add_wr_en_q", {31'h0, wr_en_q}, 32'd1);

    // asynchronous reset with wr_en_q high, away from any clock edge
    #1;
    reset = 1'b0;
    #1;
    chk("async_res_q", res_q, 32'h0);
    chk("async_wr_reg_q", {27'h0, wr_reg_q}, 32'h0);
    chk("async_wr_en_q", {31'h0, wr_en_q}, 32'h0);
    chk("async_comb_y", alu_y, 32'd12);
    #1;
    reset = 1'b1;

    @(negedge clk);
    apply(itype(6'b001000, 5'd1, 5'd4, 16'hFFFF), 32'd1, 32'd0);
    chk("addi_y", alu_y, 32'h0);
    chk("addi_zero", {31'h0, zero}, 32'd1);
    chk("addi_ctl", {25'h0, ctl}, {25'h0, 7'b1000100});
    tick();
    chk("addi_wr_reg_q", {27'h0, wr_reg_q}, 32'd4);

    apply(itype(6'b001101, 5'd1, 5'd4, 16'hFFFF), 32'd1, 32'd0);
    chk("ori_y", alu_y, 32'h0000FFFF);
    chk("ori_aluop", {30'h0, ALUOp}, 32'd3);
    apply(itype(6'b001100, 5'd1, 5'd4, 16'h80F0), 32'hFFFFFFFF, 32'd0);
    chk("andi_y", alu_y, 32'h000080F0);
    apply(itype(6'b001010, 5'd1, 5'd4, 16'hFFFF), 32'hFFFFFFFE, 32'd0);
    chk("slti_y", alu_y, 32'd1);

    apply(itype(6'b100011, 5'd2, 5'd6, 16'hFFFC), 32'h100, 32'd0);
    chk("lw_y", alu_y, 32'h000000FC);
    chk("lw_ctl", {25'h0, ctl}, {25'h0, 7'b1100100});
    tick();
    chk("lw_q", {25'h0, qv}, {25'h0, 7'b1100000});
    chk("lw_wr_reg_q", {27'h0, wr_reg_q}, 32'd6);

    apply(itype(6'b101011, 5'd2, 5'd6, 16'h0008), 32'h100, 32'd0);
    chk("sw_y", alu_y, 32'h108);
    tick();
    chk("sw_q", {25'h0, qv}, {25'h0, 7'b0010000});

    // unknown opcode right after sw: the pending mem write must drop
    apply(32'hFC00_0000, 32'd3, 32'd4);
    chk("ill_flag", {31'h0, illegal}, 32'd1);
    chk("ill_ctl", {25'h0, ctl}, 32'h0);
    tick();
    chk("ill_q", {25'h0, qv}, 32'h0);

    apply(itype(6'b000100, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9);
    chk("beq_pcsrc", {31'h0, PCSrc}, 32'd1);
    chk("beq_ctl", {25'h0, ctl}, {25'h0, 7'b0000010});
    apply(itype(6'b000101, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9);
    chk("bne_eq_pcsrc", {31'h0, PCSrc}, 32'd0);
    chk("bne_regwrite", {31'h0, RegWrite}, 32'd0);
    apply(itype(6'b000101, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd8);
    chk("bne_ne_pcsrc", {31'h0, PCSrc}, 32'd1);

    apply(rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'b000011), 32'd0, 32'h80000000);
    chk("sra_y", alu_y, 32'hF8000000);
    apply(rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'b000010), 32'd0, 32'h80000000);
    chk("srl_y", alu_y, 32'h08000000);
    apply(rtype(5'd0, 5'd2, 5'd3, 5'd31, 6'b000000), 32'd0, 32'd1);
    chk("sll_y", alu_y, 32'h80000000);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b101010), 32'hFFFFFFFF, 32'd1);
    chk("slt_neg_y", alu_y, 32'd1);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b101010), 32'd1, 32'hFFFFFFFF);
    chk("slt_pos_y", alu_y, 32'd0);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100010), 32'd5, 32'd7);
    chk("sub_y", alu_y, 32'hFFFFFFFE);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100111), 32'h0F0F0000, 32'h00000F0F);
    chk("nor_y", alu_y, 32'hF0F0F0F0);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100110), 32'hFF00FF00, 32'h0FF00FF0);
    chk("xor_y", alu_y, 32'hF0F0F0F0);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100101), 32'hFF000000, 32'h000000FF);
    chk("or_y", alu_y, 32'hFF0000FF);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100100), 32'hFF00FF00, 32'h0FF00FF0);
    chk("and_y", alu_y, 32'h0F000F00);
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'hFFFFFFFF, 32'd2);
    chk("add_wrap_y", alu_y, 32'd1);
    tick();
    chk("add_wrap_wr_en_q", {31'h0, wr_en_q}, 32'd1);

    // unknown funct under R-type: RegWrite stays decoded but no write happens
    apply(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b111111), 32'd5, 32'd7);
    chk("badfn_illegal", {31'h0, illegal}, 32'd1);
    chk("badfn_y", alu_y, 32'h0);
    tick();
    chk("badfn_wr_en_q", {31'h0, wr_en_q}, 32'd0);

    apply({6'b000010, 26'h2ABCDEF}, 32'd0, 32'd0);
    chk("j_ctl", {25'h0, ctl}, {25'h0, 7'b0000001});
    chk("j_address", {6'h0, address}, {6'h0, 26'h2ABCDEF});
    chk("j_pcsrc", {31'h0, PCSrc}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
